// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants and types shared by the instruction-fetch stage.
//   - default reset vector
//   - csr_vec_h bit index for instruction-address-misaligned
//   - BOOT/RUN state encodings
//   - stall vector bit index for IF
package if_stage_pkg;

  localparam logic [63:0] IF_RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam int          CSR_IAM_BIT     = 0;
  localparam int          STALL_IF_BIT    = 0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } if_state_t;

  // Instruction-address-misaligned test on a fetch address.
  function automatic logic pc_misaligned(input logic [63:0] a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// if_redirect_buf: remembers a branch that resolves while fetch is stalled.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   run              fetch FSM is in RUN (captures are ignored in BOOT)
//   flush            trap/return redirect, discards any pending branch
//   stall_if         IF stall
//   br_e, br_addr    taken branch and its target
//   pend, pend_addr  pending branch flag and target
module if_redirect_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        flush,
  input  logic        stall_if,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pend,
  output logic [63:0] pend_addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= 64'd0;
    end else if (run) begin
      if (flush) begin
        pend <= 1'b0;
      end else if (br_e && stall_if) begin
        // a newer branch overwrites an older pending target
        pend      <= 1'b1;
        pend_addr <= br_addr;
      end else if (!stall_if) begin
        // taken directly by the PC, or consumed from the buffer
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, drives the instruction
// SRAM read port and hands pc/pc_valid/csr_vec_h to decode.
// Optional build macro: IF_MISALIGN_CHK_EN enables the instruction-address-
// misaligned check (csr_vec_h[0]) and the matching SRAM read suppression.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush, new_pc     trap/mret redirect and target
//   stall             pipeline stall vector, bit STALL_IF_BIT used
//   br_e, br_addr     taken branch/jump and target
//   pc_valid, pc      registered fetch address and its valid
//   csr_vec_h         registered fetch exceptions aligned with pc
//   inst_sram_en      SRAM read enable
//   inst_sram_addr    doubleword-aligned SRAM address
//
// state   | meaning
// ST_BOOT | after reset; next edge loads RESET_PC (or flush target)
// ST_RUN  | normal fetch; redirect/stall/increment priority applies
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IF_RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [63:0] new_pc,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic [31:0] csr_vec_h,
  output logic        inst_sram_en,
  output logic [63:0] inst_sram_addr
);

  if_state_t   state, state_nxt;
  logic        stall_if;
  logic        pend;
  logic [63:0] pend_addr;
  logic        pc_ld;
  logic [63:0] pc_nxt;
  logic [31:0] csr_nxt;
  logic        unused_stall;

  assign stall_if     = stall[STALL_IF_BIT];
  assign unused_stall = ^stall;

  if_redirect_buf u_redirect_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state == ST_RUN),
    .flush     (flush),
    .stall_if  (stall_if),
    .br_e      (br_e),
    .br_addr   (br_addr),
    .pend      (pend),
    .pend_addr (pend_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // BOOT lasts exactly one edge; only reset returns to it.
  always_comb begin
    state_nxt = ST_RUN;
  end

  always_comb begin
    pc_ld  = 1'b0;
    pc_nxt = pc;
    case (state)
      ST_BOOT: begin
        pc_ld  = 1'b1;
        pc_nxt = flush ? new_pc : RESET_PC;
      end
      default: begin
        if (flush) begin
          pc_ld  = 1'b1;
          pc_nxt = new_pc;
        end else if (br_e && !stall_if) begin
          pc_ld  = 1'b1;
          pc_nxt = br_addr;
        end else if (br_e) begin
          pc_ld  = 1'b0;
        end else if (pend && !stall_if) begin
          pc_ld  = 1'b1;
          pc_nxt = pend_addr;
        end else if (stall_if) begin
          pc_ld  = 1'b0;
        end else begin
          pc_ld  = 1'b1;
          pc_nxt = pc + 64'd4;
        end
      end
    endcase
  end

  always_comb begin
    csr_nxt = 32'd0;
`ifdef IF_MISALIGN_CHK_EN
    csr_nxt[CSR_IAM_BIT] = pc_misaligned(pc_nxt);
`endif
  end

  // Holding pc, pc_valid and csr_vec_h together keeps them aligned under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= 64'd0;
      pc_valid  <= 1'b0;
      csr_vec_h <= 32'd0;
    end else if (pc_ld) begin
      pc        <= pc_nxt;
      pc_valid  <= 1'b1;
      csr_vec_h <= csr_nxt;
    end
  end

  assign inst_sram_addr = {pc[63:3], 3'b000};
  assign inst_sram_en   = pc_valid & ~csr_vec_h[CSR_IAM_BIT];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [63:0] new_pc;
  logic [5:0]  stall;
  logic        br_e;
  logic [63:0] br_addr;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] csr_vec_h;
  logic        inst_sram_en;
  logic [63:0] inst_sram_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

`ifdef IF_MISALIGN_CHK_EN
  localparam logic        MIS_CHK = 1'b1;
`else
  localparam logic        MIS_CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall          (stall),
    .br_e           (br_e),
    .br_addr        (br_addr),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .csr_vec_h      (csr_vec_h),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [63:0] exp_pc);
    chk({tag, ".pc"},    pc, exp_pc);
    chk({tag, ".valid"}, {63'd0, pc_valid}, 64'd1);
    chk({tag, ".addr"},  inst_sram_addr, {exp_pc[63:3], 3'b000});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; new_pc = '0; stall = '0; br_e = 1'b0; br_addr = '0;
    #12;
    chk("rst.pc",    pc, 64'd0);
    chk("rst.valid", {63'd0, pc_valid}, 64'd0);
    chk("rst.csr",   {32'd0, csr_vec_h}, 64'd0);
    chk("rst.en",    {63'd0, inst_sram_en}, 64'd0);
    chk("rst.addr",  inst_sram_addr, 64'd0);

    // reset release and sequential fetch
    rst_n = 1'b1;
    step(); chk_fetch("boot", B);
    chk("boot.en", {63'd0, inst_sram_en}, 64'd1);
    step(); chk_fetch("seq1", B + 64'h4);
    chk("seq1.addr_dw", inst_sram_addr, B);
    step(); chk_fetch("seq2", B + 64'h8);
    step(); step(); chk_fetch("seq4", B + 64'h10);

    // three-cycle stall
    stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("stall", B + 64'h10);
      chk("stall.en", {63'd0, inst_sram_en}, 64'd1);
    end
    stall = 6'b0;
    step(); chk_fetch("resume", B + 64'h14);

    // stall bits other than IF must not stall
    stall = 6'b111110;
    step(); chk_fetch("otherstall", B + 64'h18);
    stall = 6'b0;

    // unstalled branch
    br_e = 1'b1; br_addr = B + 64'h100;
    step(); chk_fetch("br", B + 64'h100);
    br_e = 1'b0;

    // branch under stall is remembered
    br_e = 1'b1; br_addr = B + 64'h200; stall = 6'b000001;
    step(); chk_fetch("brstall1", B + 64'h100);
    br_e = 1'b0;
    step(); chk_fetch("brstall2", B + 64'h100);
    stall = 6'b0;
    step(); chk_fetch("pendtake", B + 64'h200);
    step(); chk_fetch("pendnext", B + 64'h204);

    // newer stalled branch overwrites the pending target
    stall = 6'b000001; br_e = 1'b1; br_addr = B + 64'h500;
    step(); br_addr = B + 64'h600;
    step(); br_e = 1'b0;
    chk_fetch("ovw.hold", B + 64'h204);
    stall = 6'b0;
    step(); chk_fetch("ovw.take", B + 64'h600);

    // flush beats a new branch and a pending one, and clears the pending one
    stall = 6'b000001; br_e = 1'b1; br_addr = B + 64'h300;
    step(); chk_fetch("fl.pend", B + 64'h600);
    flush = 1'b1; new_pc = B + 64'h1000; br_addr = B + 64'h400;
    step(); chk_fetch("flush", B + 64'h1000);
    flush = 1'b0; br_e = 1'b0; stall = 6'b0;
    step(); chk_fetch("flush.next", B + 64'h1004);

    // 64-bit wrap-around
    flush = 1'b1; new_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); flush = 1'b0;
    chk_fetch("wrap.pre", 64'hFFFF_FFFF_FFFF_FFFC);
    step(); chk_fetch("wrap", 64'd0);

    // misaligned branch target
    br_e = 1'b1; br_addr = B + 64'h102;
    step(); br_e = 1'b0;
    chk_fetch("mis", B + 64'h102);
    chk("mis.csr", {32'd0, csr_vec_h}, {63'd0, MIS_CHK});
    chk("mis.en",  {63'd0, inst_sram_en}, {63'd0, ~MIS_CHK});
    step(); chk_fetch("mis.adv", B + 64'h106);
    chk("mis.adv.csr", {32'd0, csr_vec_h}, {63'd0, MIS_CHK});
    flush = 1'b1; new_pc = B + 64'h2000;
    step(); flush = 1'b0;
    chk("align.csr", {32'd0, csr_vec_h}, 64'd0);
    chk("align.en",  {63'd0, inst_sram_en}, 64'd1);

    // asynchronous reset mid-run, with a pending branch outstanding
    stall = 6'b000001; br_e = 1'b1; br_addr = B + 64'h700;
    step(); br_e = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc",    pc, 64'd0);
    chk("arst.valid", {63'd0, pc_valid}, 64'd0);
    // stall ignored on the BOOT edge; stale pending branch must be gone
    #3 rst_n = 1'b1;
    step(); chk_fetch("boot2", B);
    stall = 6'b0;
    step(); chk_fetch("boot2.next", B + 64'h4);

    // flush on the BOOT edge wins over RESET_PC
    #2 rst_n = 1'b0;
    flush = 1'b1; new_pc = B + 64'h3000;
    #3 rst_n = 1'b1;
    step(); flush = 1'b0;
    chk_fetch("bootflush", B + 64'h3000);
    step(); chk_fetch("bootflush.next", B + 64'h3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
